// File: rtl/mwb_pkg.sv
// Shared types and default sizing for the running-mean window buffer.
package mwb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;

  localparam int DEF_PTR_W  = $clog2(DEF_DEPTH);
  localparam int DEF_CNT_W  = $clog2(DEF_DEPTH) + 1;

  typedef enum logic {
    FILL   = 1'b0,
    STEADY = 1'b1
  } mwb_state_e;

endpackage

// File: rtl/mwb_ram.sv
// DEPTH x DATA_W sample store: one write port, combinational read on the same
// address, so a read in the write cycle returns the pre-write contents.
module mwb_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Deliberately unreset; the FSM masks stale contents during fill.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mean_window_buffer.sv
// Sliding-window sample store: emits each accepted sample with the one leaving
// the window (zero while filling). Optional synchronous clear via MWB_FLUSH_EN.
module mean_window_buffer
  import mwb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef MWB_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_new,
  output logic [DATA_W-1:0]      out_old,
  output logic                   out_full,
  output logic [$clog2(DEPTH):0] fill_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  mwb_state_e        state;
  logic [PW-1:0]     wr_ptr;
  logic [DATA_W-1:0] slot;
  logic              accept;
  logic              clr;

`ifdef MWB_FLUSH_EN
  assign clr      = flush;
`else
  assign clr      = 1'b0;
`endif

  assign in_ready = (!out_valid || out_ready) && !clr;
  assign accept   = in_valid && in_ready;
  assign out_full = (state == STEADY);

  mwb_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .addr  (wr_ptr),
    .wdata (in_data),
    .rdata (slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      out_new   <= '0;
      out_old   <= '0;
    end else if (clr) begin
      // Sample data registers keep their value; out_valid=0 hides them.
      state     <= FILL;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_new   <= in_data;
      out_old   <= (state == STEADY) ? slot : '0;
      wr_ptr    <= wr_ptr + PW'(1);
      if (state == FILL) begin
        fill_cnt <= fill_cnt + CW'(1);
        if (fill_cnt == CNT_LAST) state <= STEADY;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mean_window_buffer.md
# mean_window_buffer

Sliding-window sample store for the running-mean datapath. It accepts one new sample per handshake and retains the last DEPTH samples in a circular buffer. It emits each new sample together with the sample leaving the window, which feed the running-sum update (sum + new − old). During the initial fill the leaving sample is zero, so the downstream sum ramps correctly from reset.

## Interface
- DATA_W, 32: sample width, two's complement.
- DEPTH, 16: window length; power of two, ≥ 2.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  buffer can accept a sample.
- in_data  in  DATA_W  incoming sample.
- out_valid  out  1  output pair valid.
- out_ready  in  1  downstream accepts the output pair.
- out_new  out  DATA_W  sample just accepted.
- out_old  out  DATA_W  sample evicted from the window; zero while filling.
- out_full  out  1  window holds DEPTH samples.
- fill_cnt  out  $clog2(DEPTH)+1  number of valid samples held; saturates at DEPTH.
- flush  in  1  synchronous window clear; present only with MWB_FLUSH_EN.

## Operation
- Accept when in_valid && in_ready; in_ready = !out_valid || out_ready.
- On accept:
  - The slot at wr_ptr is read before it is written.
  - out_old <= (state == STEADY) ? slot : 0.
  - out_new <= in_data.
  - The slot is written with in_data.
  - wr_ptr advances, wrapping from DEPTH-1 to 0.
- State machine:
  - FILL: fill_cnt < DEPTH.
  - STEADY: the window is full. Entered on the accept that makes fill_cnt == DEPTH.
  - STEADY is left only on reset or flush.
- fill_cnt increments on each accept in FILL and holds in STEADY. out_full = (state == STEADY).
- Output register:
  - out_valid sets on accept.
  - out_valid clears on out_ready when there is no simultaneous accept.
  - Accept with out_ready in the same cycle gives back-to-back throughput: out_valid stays 1 and the data is replaced.
- Data is unmodified and carries no arithmetic. The old value is exactly the sample accepted DEPTH accepts earlier.
- Storage is not reset. Zero-during-fill comes from the state, not from memory contents.

## Timing
- Latency is 1 cycle from accept to out_valid with the corresponding out_new/out_old.
- Throughput is one sample per cycle when out_ready is held high.
- While out_valid && !out_ready: all outputs are held stable and in_ready = 0.
- Reset values: out_valid 0, out_new 0, out_old 0, out_full 0, fill_cnt 0, wr_ptr 0, state FILL. in_ready is 1 during and after reset.
- Reset asserted mid-stream: the pending output is discarded immediately (asynchronously). The next accepted sample sees out_old = 0.
- flush (with macro):
  - Next edge: wr_ptr, fill_cnt, out_valid and state return to reset values.
  - flush has priority over a simultaneous accept, and that sample is dropped.
  - in_ready is forced to 0 while flush is high.

## Configuration
- MWB_FLUSH_EN defined: the flush port exists with the behaviour above.
- MWB_FLUSH_EN undefined: there is no flush port, and the window clears only via rst_n.

## Structure
- Shared package mwb_pkg:
  - Default DATA_W and DEPTH.
  - State enum {FILL, STEADY}.
  - Pointer width localparam $clog2(DEPTH) and count width $clog2(DEPTH)+1.
- Sub-module mwb_ram: DEPTH × DATA_W storage with one write port and a combinational read port on the same address. Read returns the pre-write contents.
- Top level holds the pointer, counter, FSM and output register.

## Test plan
All scenarios use DEPTH = 4.
- Reset, then feed 1, 2, 3, 4 with out_ready = 1 → out_new 1..4 and out_old 0, 0, 0, 0. fill_cnt goes 1..4, and out_full rises with the 4th output.
- Continue with 5, 6, 7, 8, 9 → out_old = 1, 2, 3, 4, 5. The wrap of wr_ptr is exercised twice.
- Hold out_ready = 0 after sample 5 while in_valid = 1 with data 6 → in_ready = 0 and outputs frozen at (5, 1). Release → (6, 2) follows one cycle later, with no loss or duplication.
- Assert rst_n low for one cycle after sample 6 → outputs are 0 at once. Then feed 10 → (10, 0) and fill_cnt = 1.
- With the macro: flush together with in_valid carrying 7, after the window is full → sample dropped, fill_cnt = 0. The next sample 8 gives out_old 0.
- Continuous in_valid/out_ready with 100 random samples → every out_old equals the sample four accepts earlier, and there are no bubbles.
